// File: rtl/code_sender.sv
// Transmit side of the keypad lock link. It shifts a stored code onto the
// lock's digit bus, watches the unlock flag for a bounded window, and retries.
module code_sender #(
  parameter  int DIGIT_W     = 3,
  parameter  int NUM_DIGITS  = 4,
  parameter  int WAIT_CYCLES = 4,
  parameter  int MAX_RETRY   = 2,
  localparam int RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_prog,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_code,
  input  logic                          i_unlock_in,
  output logic [DIGIT_W-1:0]            o_digit_out,
  output logic                          o_digit_valid,
  output logic                          o_sel_out,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_granted,
  output logic                          o_fail,
  output logic [RW-1:0]                 o_retry_cnt
);

  localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);
  localparam logic [RW-1:0] MAX_RC   = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  typedef struct packed {
    logic                               prog;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] code;
  } req_t;

  state_t                             r_state;
  req_t                               r_req;
  logic [IW-1:0]                      r_idx;
  logic [CW-1:0]                      r_cnt;
  logic [IW-1:0]                      w_idx_nxt;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_code_in;

  assign w_code_in = i_code;
  assign w_idx_nxt = r_idx + 1'b1;

  // Outputs are registered with the state they belong to, so every branch
  // loads the values the lock must see in the cycle being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_req         <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      o_digit_out   <= '0;
      o_digit_valid <= 1'b0;
      o_sel_out     <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_granted     <= 1'b0;
      o_fail        <= 1'b0;
      o_retry_cnt   <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_req.prog  <= i_prog;
            r_req.code  <= w_code_in;
            r_idx       <= '0;
            o_granted   <= 1'b0;
            o_fail      <= 1'b0;
            o_retry_cnt <= '0;
            // A locked lock cannot be reprogrammed; fail without sending.
            if (i_prog && !i_unlock_in) begin
              r_state <= DONE;
              o_done  <= 1'b1;
              o_fail  <= 1'b1;
            end else begin
              r_state       <= SEND;
              o_busy        <= 1'b1;
              o_digit_valid <= 1'b1;
              o_digit_out   <= w_code_in[0];
              o_sel_out     <= i_prog;
            end
          end
        end
        SEND: begin
          if (r_idx == LAST_IDX) begin
            r_idx         <= '0;
            o_digit_valid <= 1'b0;
            o_digit_out   <= '0;
            o_sel_out     <= 1'b0;
            if (r_req.prog) begin
              r_state   <= DONE;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
              o_granted <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= '0;
            end
          end else begin
            r_idx       <= w_idx_nxt;
            o_digit_out <= r_req.code[w_idx_nxt];
          end
        end
        WAIT: begin
          if (i_unlock_in) begin
            r_state   <= DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_granted <= 1'b1;
          end else if (r_cnt == LAST_CNT) begin
            if (o_retry_cnt != MAX_RC) begin
              r_state       <= SEND;
              r_idx         <= '0;
              o_retry_cnt   <= o_retry_cnt + 1'b1;
              o_digit_valid <= 1'b1;
              o_digit_out   <= r_req.code[0];
              o_sel_out     <= r_req.prog;
            end else begin
              r_state <= DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              o_fail  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_sender.sv
// Randomized bench for code_sender: a per-cycle expectation trace is built
// from the attempt/window rules and compared against the DUT every cycle.
module tb_code_sender;
  localparam int DW = 3, ND = 4, WC = 4, MR = 2, RW = 2, NC = 64;

  logic              i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_prog = 1'b0;
  logic [ND*DW-1:0]  i_code = '0;
  logic              i_unlock_in = 1'b0;
  logic [DW-1:0]     o_digit_out;
  logic              o_digit_valid, o_sel_out, o_busy, o_done, o_granted, o_fail;
  logic [RW-1:0]     o_retry_cnt;

  int n_cmp = 0, n_err = 0;
  int e_dv[NC], e_d[NC], e_sel[NC], e_busy[NC], e_done[NC], e_gr[NC], e_fail[NC], e_rc[NC];

  code_sender #(.DIGIT_W(DW), .NUM_DIGITS(ND), .WAIT_CYCLES(WC), .MAX_RETRY(MR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_prog(i_prog),
    .i_code(i_code), .i_unlock_in(i_unlock_in), .o_digit_out(o_digit_out),
    .o_digit_valid(o_digit_valid), .o_sel_out(o_sel_out), .o_busy(o_busy),
    .o_done(o_done), .o_granted(o_granted), .o_fail(o_fail), .o_retry_cnt(o_retry_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Cycle c is the clock period following edge c-1; start is taken at edge 0.
  // unl[c] is the lock flag presented during cycle c.
  task automatic build(input logic [ND*DW-1:0] code, input bit prog,
                       input bit [NC-1:0] unl, output int done_c);
    int t, a;
    bit g;
    for (int c = 0; c < NC; c++) begin
      e_dv[c] = 0; e_d[c] = 0; e_sel[c] = 0; e_busy[c] = 0;
      e_done[c] = 0; e_gr[c] = 0; e_fail[c] = 0; e_rc[c] = 0;
    end
    t = 1; a = 0; g = 0; done_c = 0;
    if (prog && !unl[0]) done_c = 1;
    while (done_c == 0) begin
      for (int k = 0; k < ND; k++) begin
        e_dv[t] = 1; e_d[t] = int'((code >> (k*DW)) & 12'h7);
        e_sel[t] = int'(prog); e_busy[t] = 1; e_rc[t] = a; t++;
      end
      if (prog) begin
        done_c = t; g = 1;
      end else begin
        for (int w = 0; w < WC && done_c == 0; w++) begin
          e_busy[t] = 1; e_rc[t] = a;
          if (unl[t]) begin done_c = t + 1; g = 1; end
          t++;
        end
        if (done_c == 0) begin
          if (a == MR) done_c = t;
          else a++;
        end
      end
    end
    e_done[done_c] = 1;
    for (int c = done_c; c < NC; c++) begin
      e_gr[c] = int'(g); e_fail[c] = int'(!g); e_rc[c] = a;
    end
  endtask

  task automatic chk_cycle(input string nm, input int c);
    chk($sformatf("%s c%0d valid", nm, c), int'(o_digit_valid), e_dv[c]);
    chk($sformatf("%s c%0d digit", nm, c), int'(o_digit_out), e_d[c]);
    chk($sformatf("%s c%0d sel", nm, c), int'(o_sel_out), e_sel[c]);
    chk($sformatf("%s c%0d busy", nm, c), int'(o_busy), e_busy[c]);
    chk($sformatf("%s c%0d done", nm, c), int'(o_done), e_done[c]);
    chk($sformatf("%s c%0d granted", nm, c), int'(o_granted), e_gr[c]);
    chk($sformatf("%s c%0d fail", nm, c), int'(o_fail), e_fail[c]);
    chk($sformatf("%s c%0d retry", nm, c), int'(o_retry_cnt), e_rc[c]);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, int'(o_digit_valid), 0);
    chk({nm, " digit"}, int'(o_digit_out), 0);
    chk({nm, " sel"}, int'(o_sel_out), 0);
    chk({nm, " busy"}, int'(o_busy), 0);
    chk({nm, " done"}, int'(o_done), 0);
    chk({nm, " granted"}, int'(o_granted), 0);
    chk({nm, " fail"}, int'(o_fail), 0);
    chk({nm, " retry"}, int'(o_retry_cnt), 0);
  endtask

  // spam: pulse start (with junk prog/code) while busy and in the DONE cycle.
  task automatic run(input string nm, input logic [ND*DW-1:0] code, input bit prog,
                     input bit [NC-1:0] unl, input bit spam, input int abort_c);
    int dc;
    build(code, prog, unl, dc);
    @(negedge i_clk);
    i_start = 1'b1; i_prog = prog; i_code = code; i_unlock_in = unl[0];
    for (int c = 1; c <= dc + 2; c++) begin
      @(negedge i_clk);
      if (c == abort_c) begin
        i_rst_n = 1'b0;
        #1 chk_zero($sformatf("%s rst c%0d", nm, c));
        @(posedge i_clk); #1;
        chk_zero($sformatf("%s rst hold", nm));
        @(negedge i_clk);
        i_rst_n = 1'b1; i_start = 1'b0; i_unlock_in = 1'b0;
        return;
      end
      chk_cycle(nm, c);
      i_start = spam && (c <= dc) && ($urandom_range(0, 1) == 1);
      i_prog = 1'($urandom); i_code = 12'($urandom);
      i_unlock_in = unl[c];
    end
    i_start = 1'b0; i_unlock_in = 1'b0;
  endtask

  initial begin
    bit [NC-1:0] u;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk_zero("idle");

    run("basic",    12'o4321, 1'b0, 64'h40, 1'b0, 0);
    run("nounlock", 12'o1234, 1'b0, 64'h0, 1'b0, 0);
    run("prog_ok",  12'o7070, 1'b1, '1, 1'b0, 0);
    run("prog_nok", 12'o5555, 1'b1, 64'h0, 1'b0, 0);
    run("send_unl", 12'o2461, 1'b0, 64'h1E, 1'b0, 0);
    run("last_win", 12'o3017, 1'b0, 64'h100, 1'b0, 0);
    run("busy_st",  12'o6543, 1'b0, 64'h4000, 1'b1, 0);
    run("abort",    12'o7654, 1'b0, 64'h0, 1'b0, 3);
    run("post_rst", 12'o0127, 1'b0, 64'h2000, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: u = '0;
        1: u = 64'(1) << $urandom_range(0, 26);
        default: u = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      endcase
      run($sformatf("rnd%0d", i), 12'($urandom), ($urandom_range(0, 3) == 0),
          u, 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/code_sender.md
# code_sender

Transmit-side companion to the keypad combination lock. Serializes a stored multi-digit code onto the lock's digit bus, one digit per clock, then watches the lock's unlock flag for a bounded response window. Retries a configurable number of times and reports grant or failure. Also drives programming sequences (select asserted) to load a new code into an already-unlocked lock.

## Interface
- DIGIT_W, 3, width of one code digit
- NUM_DIGITS, 4, digits per code
- WAIT_CYCLES, 4, response-window length in clocks after the last digit (≥1)
- MAX_RETRY, 2, extra attempts after the first failed attempt (≥0)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a transaction; sampled only in IDLE
- prog  in  1  sampled with start; 1 = programming sequence, 0 = unlock attempt
- code  in  NUM_DIGITS*DIGIT_W  code to send; digit k = code[k*DIGIT_W +: DIGIT_W], digit 0 sent first
- unlock_in  in  1  unlock flag from lock (its y output)
- digit_out  out  DIGIT_W  digit presented to lock
- digit_valid  out  1  digit_out carries a code digit this cycle
- sel_out  out  1  lock select (programming) line
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- granted  out  1  last transaction succeeded; held until next accepted start
- fail  out  1  last transaction failed; held until next accepted start
- retry_cnt  out  clog2(MAX_RETRY+1), min 1  retries used in current/last transaction

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE: busy=0. On start=1, latch code and prog, clear granted, fail, retry_cnt; go SEND with digit index 0. start is ignored in every other state.
- Programming with unlock_in=0 at start: skip SEND; go straight to DONE with fail=1.
- SEND: digit_out = latched digit[index]; digit_valid=1; sel_out = latched prog. Index increments every cycle. After index NUM_DIGITS-1:
  - programming: go DONE, granted=1.
  - unlock attempt: go WAIT, window counter = 0.
- unlock_in is ignored during SEND, because it is stale from an earlier code.
- WAIT: digit_valid=0, digit_out=0. Counter increments every cycle.
  - unlock_in=1 in any WAIT cycle, including the last: go DONE, granted=1.
  - Window expires (WAIT_CYCLES cycles with no unlock) and retry_cnt < MAX_RETRY: retry_cnt+1, go SEND at index 0.
  - Window expires and retry_cnt = MAX_RETRY: go DONE, fail=1.
- DONE: done=1 for exactly one cycle; busy=0; then IDLE. A start in the DONE cycle is ignored.
- granted and fail are never 1 together.

## Timing
- All outputs are registered.
- Reset values: digit_out=0, digit_valid=0, sel_out=0, busy=0, done=0, granted=0, fail=0, retry_cnt=0; state IDLE.
- Reset asserted mid-transaction aborts immediately to those values. No done pulse is produced.
- Start accepted at edge 0: digit k is valid in cycle k+1 for k = 0..NUM_DIGITS-1, and busy=1 from cycle 1.
- With defaults, digits occupy cycles 1–4 and WAIT occupies cycles 5–8.
- unlock_in sampled at WAIT cycle c: done and granted appear in cycle c+1.
- Window expiry:
  - with a retry left, digit 0 is re-sent in the cycle after the last WAIT cycle; there are no gap cycles.
  - on final failure, done and fail appear in the cycle after the last WAIT cycle.
- Worst-case unlock latency, start to done: (MAX_RETRY+1)*(NUM_DIGITS+WAIT_CYCLES)+1 cycles. This is 25 with defaults.
- Programming latency, start to done: NUM_DIGITS+1 cycles. This is 5 with defaults.

## Test plan
- Reset release, then start with code=12'o4321, prog=0; lock model unlocks in WAIT cycle 2 -> digit_out 1,2,3,4 on cycles 1–4 with digit_valid=1; done and granted=1 in cycle 7; retry_cnt=0.
- Lock never unlocks -> three full send/wait sequences; retry_cnt reaches 2; done and fail=1 in cycle 25; granted=0.
- Programming with unlock_in=1, code=12'o7070 -> sel_out=1 and digits 0,7,0,7 on cycles 1–4; done and granted=1 in cycle 5.
- Programming with unlock_in=0 -> done and fail=1 in cycle 1; digit_valid never asserts.
- Boundary conditions:
  - unlock_in pulsed only during SEND -> ignored, so the transaction continues to WAIT.
  - unlock_in pulsed only in the last WAIT cycle -> granted.
  - start pulsed while busy -> no effect.
- rst_n asserted in cycle 3 of a send -> all outputs 0 on the same edge; no done pulse; a new start after release works normally.
